// File: rtl/mode_seq_pkg.sv
// Shared key codes, stopwatch command encodings and sequencer state enumeration.
package mode_seq_pkg;

    localparam int unsigned KEY_W       = 4;
    localparam int unsigned OPERAND_W   = 7;
    localparam int unsigned SW_CMD_W    = 2;
    localparam int unsigned DIGIT_CNT_W = 2;
    localparam int unsigned MAX_DIGITS  = 2;

    localparam logic [KEY_W-1:0] KEY_MAX_DIGIT = 4'd9;
    localparam logic [KEY_W-1:0] KEY_CLEAR     = 4'd10;
    localparam logic [KEY_W-1:0] KEY_START     = 4'd11;
    localparam logic [KEY_W-1:0] KEY_RESUME    = 4'd12;
    localparam logic [KEY_W-1:0] KEY_STOP      = 4'd13;
    localparam logic [KEY_W-1:0] KEY_ADD       = 4'd14;
    localparam logic [KEY_W-1:0] KEY_SUB       = 4'd15;

    typedef enum logic [SW_CMD_W-1:0] {
        SW_STOP  = 2'd0,
        SW_RUN   = 2'd1,
        SW_CLEAR = 2'd2
    } sw_cmd_e;

    typedef enum logic [2:0] {
        SW,
        CALC_A,
        CALC_B,
        EXEC,
        RESULT
    } state_e;

    // Keys 0-9 are numeric digits; everything above is a command key.
    function automatic logic is_digit(input logic [KEY_W-1:0] k);
        return (k <= KEY_MAX_DIGIT);
    endfunction

    // Add and subtract share the operator-select behaviour.
    function automatic logic is_op_key(input logic [KEY_W-1:0] k);
        return (k == KEY_ADD) || (k == KEY_SUB);
    endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// Keypad/calculator/stopwatch signal bundle for the mode sequencer.
interface mode_sequencer_if;
    import mode_seq_pkg::*;

    logic [KEY_W-1:0]     key;
    logic                 key_valid;
    logic                 calc_done;
    logic                 mode;
    logic [SW_CMD_W-1:0]  sw_cmd;
    logic                 lap_capture;
    logic [OPERAND_W-1:0] operand_a;
    logic [OPERAND_W-1:0] operand_b;
    logic                 op;
    logic                 calc_start;
    logic                 result_valid;
    logic                 calc_error;

    // Keypad / calculator side: drives keys and done, observes sequencer outputs.
    modport master (
        output key, key_valid, calc_done,
        input  mode, sw_cmd, lap_capture, operand_a, operand_b,
               op, calc_start, result_valid, calc_error
    );

    // Sequencer side.
    modport slave (
        input  key, key_valid, calc_done,
        output mode, sw_cmd, lap_capture, operand_a, operand_b,
               op, calc_start, result_valid, calc_error
    );

endinterface

// File: rtl/mode_sequencer_operand_entry.sv
// Operand register with a two-digit entry counter (clear, load-digit, accumulate).
module operand_entry
    import mode_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 acc,
    input  logic [KEY_W-1:0]     digit,
    output logic [OPERAND_W-1:0] value
);

    logic [OPERAND_W-1:0]   value_q, value_d;
    logic [DIGIT_CNT_W-1:0] cnt_q, cnt_d;

    // Clear beats load beats accumulate; a third accumulated digit is dropped.
    always_comb begin
        value_d = value_q;
        cnt_d   = cnt_q;
        if (clr) begin
            value_d = '0;
            cnt_d   = '0;
        end else if (load) begin
            value_d = OPERAND_W'(digit);
            cnt_d   = DIGIT_CNT_W'(1);
        end else if (acc && (cnt_q < DIGIT_CNT_W'(MAX_DIGITS))) begin
            value_d = OPERAND_W'(value_q * OPERAND_W'(10)) + OPERAND_W'(digit);
            cnt_d   = cnt_q + DIGIT_CNT_W'(1);
        end
    end

    // Operand and digit-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/mode_sequencer.sv
// Keypad mode sequencer: routes keys to a stopwatch or a two-operand calculator.
// Optional EXEC timeout is built only when MODE_SEQ_TIMEOUT_EN is defined.
module mode_sequencer
    import mode_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst,
    mode_sequencer_if.slave   bus
);

    state_e  state_q, state_d;
    sw_cmd_e sw_cmd_q, sw_cmd_d;
    logic    mode_q, mode_d;
    logic    lap_q, lap_d;
    logic    op_q, op_d;
    logic    start_q, start_d;
    logic    rv_q, rv_d;

    logic    a_clr, a_load, a_acc;
    logic    b_clr, b_acc;
    logic    tmo_hit_c;

    logic [OPERAND_W-1:0] opa_val, opb_val;

    logic             kv;
    logic [KEY_W-1:0] k;

    assign kv = bus.key_valid;
    assign k  = bus.key;

    operand_entry u_operand_a (
        .clk   (clk),
        .rst   (rst),
        .clr   (a_clr),
        .load  (a_load),
        .acc   (a_acc),
        .digit (k),
        .value (opa_val)
    );

    operand_entry u_operand_b (
        .clk   (clk),
        .rst   (rst),
        .clr   (b_clr),
        .load  (1'b0),
        .acc   (b_acc),
        .digit (k),
        .value (opb_val)
    );

    // Next-state and next-output decode for every key / done event.
    always_comb begin
        state_d  = state_q;
        sw_cmd_d = sw_cmd_q;
        op_d     = op_q;
        rv_d     = rv_q;
        lap_d    = 1'b0;
        start_d  = 1'b0;
        a_clr    = 1'b0;
        a_load   = 1'b0;
        a_acc    = 1'b0;
        b_clr    = 1'b0;
        b_acc    = 1'b0;

        case (state_q)
            SW: begin
                if (kv) begin
                    if (k == KEY_START) begin
                        sw_cmd_d = SW_RUN;
                        lap_d    = 1'b1;
                    end else if (k == KEY_RESUME) begin
                        sw_cmd_d = SW_RUN;
                    end else if (k == KEY_STOP) begin
                        sw_cmd_d = SW_STOP;
                    end else if (k == KEY_CLEAR) begin
                        sw_cmd_d = SW_CLEAR;
                    end else if (is_op_key(k)) begin
                        op_d    = (k == KEY_SUB);
                        a_clr   = 1'b1;
                        b_clr   = 1'b1;
                        rv_d    = 1'b0;
                        state_d = CALC_A;
                    end
                end
            end

            CALC_A, CALC_B: begin
                if (kv) begin
                    if (is_digit(k)) begin
                        a_acc = (state_q == CALC_A);
                        b_acc = (state_q == CALC_B);
                    end else if (is_op_key(k)) begin
                        op_d    = (k == KEY_SUB);
                        state_d = CALC_B;
                    end else if (k == KEY_START) begin
                        // Equals needs a second operand slot to be open.
                        if (state_q == CALC_B) begin
                            start_d = 1'b1;
                            state_d = EXEC;
                        end
                    end else if (k == KEY_CLEAR) begin
                        a_clr   = 1'b1;
                        b_clr   = 1'b1;
                        state_d = CALC_A;
                    end else if (k == KEY_STOP) begin
                        rv_d    = 1'b0;
                        state_d = SW;
                    end
                end
            end

            EXEC: begin
                // Keys are dropped here; calc_done wins any coincidence.
                if (bus.calc_done) begin
                    rv_d    = 1'b1;
                    state_d = RESULT;
                end else if (tmo_hit_c) begin
                    rv_d    = 1'b0;
                    state_d = RESULT;
                end
            end

            RESULT: begin
                if (kv) begin
                    if (is_digit(k)) begin
                        a_load  = 1'b1;
                        b_clr   = 1'b1;
                        rv_d    = 1'b0;
                        state_d = CALC_A;
                    end else if (is_op_key(k)) begin
                        b_clr   = 1'b1;
                        op_d    = (k == KEY_SUB);
                        state_d = CALC_B;
                    end else if (k == KEY_STOP) begin
                        rv_d    = 1'b0;
                        state_d = SW;
                    end
                end
            end

            default: state_d = SW;
        endcase

        mode_d = (state_d != SW);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SW;
            sw_cmd_q <= SW_STOP;
            mode_q   <= 1'b0;
            lap_q    <= 1'b0;
            op_q     <= 1'b0;
            start_q  <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sw_cmd_q <= sw_cmd_d;
            mode_q   <= mode_d;
            lap_q    <= lap_d;
            op_q     <= op_d;
            start_q  <= start_d;
            rv_q     <= rv_d;
        end
    end

`ifdef MODE_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;

    assign tmo_hit_c = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count EXEC cycles without calc_done; the counter idles at zero elsewhere.
    always_comb begin
        tmo_cnt_d = '0;
        if ((state_q == EXEC) && !bus.calc_done && !tmo_hit_c) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
    end

    // Error flags a timed-out EXEC and clears on every fresh entry into CALC_A.
    always_comb begin
        err_d = err_q;
        if ((state_q == EXEC) && !bus.calc_done && tmo_hit_c) begin
            err_d = 1'b1;
        end else if ((state_d == CALC_A) && (state_q != CALC_A)) begin
            err_d = 1'b0;
        end
    end

    // Timeout counter and error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.calc_error = err_q;
`else
    // TIMEOUT_CYCLES only sizes the timeout counter, which this build omits.
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
    end

    assign tmo_hit_c      = 1'b0;
    assign bus.calc_error = 1'b0;
`endif

    assign bus.mode         = mode_q;
    assign bus.sw_cmd       = sw_cmd_q;
    assign bus.lap_capture  = lap_q;
    assign bus.operand_a    = opa_val;
    assign bus.operand_b    = opb_val;
    assign bus.op           = op_q;
    assign bus.calc_start   = start_q;
    assign bus.result_valid = rv_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: directed scenarios plus random keys against a behavioural model.
module tb_mode_sequencer;

    localparam int unsigned TMO = 8;
`ifdef MODE_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mode_sequencer_if bus();

    mode_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: phase names are plain integers, values are plain ints.
    localparam int P_WATCH = 0, P_FIRST = 1, P_SECOND = 2, P_BUSY = 3, P_SHOW = 4;
    int m_ph, m_sw, m_a, m_b, m_ac, m_bc, m_wait;
    bit m_mode, m_lap, m_op, m_start, m_rv, m_err;

    task automatic model_step(input int r, input int kv, input int k, input int d);
        bit dig;
        dig     = (k <= 9);
        m_lap   = 0;
        m_start = 0;
        if (r != 0) begin
            m_ph = P_WATCH; m_sw = 0; m_a = 0; m_b = 0; m_ac = 0; m_bc = 0;
            m_op = 0; m_rv = 0; m_err = 0; m_wait = 0;
        end else begin
            case (m_ph)
                P_WATCH: if (kv != 0) begin
                    if (k == 11) begin m_sw = 1; m_lap = 1; end
                    else if (k == 12) m_sw = 1;
                    else if (k == 13) m_sw = 0;
                    else if (k == 10) m_sw = 2;
                    else if (k >= 14) begin
                        m_op = (k == 15); m_a = 0; m_b = 0; m_ac = 0; m_bc = 0;
                        m_rv = 0; m_err = 0; m_ph = P_FIRST;
                    end
                end
                P_FIRST, P_SECOND: if (kv != 0) begin
                    if (dig) begin
                        if (m_ph == P_FIRST) begin
                            if (m_ac < 2) begin m_a = m_a * 10 + k; m_ac++; end
                        end else begin
                            if (m_bc < 2) begin m_b = m_b * 10 + k; m_bc++; end
                        end
                    end else if (k >= 14) begin
                        m_op = (k == 15); m_ph = P_SECOND;
                    end else if (k == 11) begin
                        if (m_ph == P_SECOND) begin m_start = 1; m_ph = P_BUSY; m_wait = 0; end
                    end else if (k == 10) begin
                        m_a = 0; m_b = 0; m_ac = 0; m_bc = 0; m_err = 0; m_ph = P_FIRST;
                    end else if (k == 13) begin
                        m_rv = 0; m_ph = P_WATCH;
                    end
                end
                P_BUSY: begin
                    if (d != 0) begin
                        m_rv = 1; m_ph = P_SHOW;
                    end else if (TO_EN) begin
                        m_wait++;
                        if (m_wait == int'(TMO)) begin m_err = 1; m_rv = 0; m_ph = P_SHOW; end
                    end
                end
                P_SHOW: if (kv != 0) begin
                    if (dig) begin
                        m_a = k; m_ac = 1; m_b = 0; m_bc = 0; m_rv = 0; m_err = 0; m_ph = P_FIRST;
                    end else if (k >= 14) begin
                        m_b = 0; m_bc = 0; m_op = (k == 15); m_ph = P_SECOND;
                    end else if (k == 13) begin
                        m_rv = 0; m_ph = P_WATCH;
                    end
                end
                default: m_ph = P_WATCH;
            endcase
        end
        m_mode = (m_ph != P_WATCH);
    endtask

    function automatic logic [21:0] model_vec();
        return {m_mode, 2'(m_sw), m_lap, 7'(m_a), 7'(m_b), m_op, m_start, m_rv, m_err};
    endfunction

    logic [21:0] obs;
    assign obs = {bus.mode, bus.sw_cmd, bus.lap_capture, bus.operand_a, bus.operand_b,
                  bus.op, bus.calc_start, bus.result_valid, bus.calc_error};

    // One clock: drive at negedge, model the edge, leave sampling at posedge+1.
    task automatic drive(input int r, input int kv, input int k, input int d);
        @(negedge clk);
        rst           = 1'(r);
        bus.key_valid = 1'(kv);
        bus.key       = 4'(k);
        bus.calc_done = 1'(d);
        @(posedge clk);
        model_step(r, kv, k, d);
        #1;
        rst           = 1'b0;
        bus.key_valid = 1'b0;
        bus.calc_done = 1'b0;
    endtask

    task automatic press(input int k);
        drive(0, 1, k, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, int'($urandom_range(0, 15)), 0);
    endtask

    task automatic test_reset();
        drive(1, 1, 14, 1);
        drive(1, 1, 11, 0);
        total++; if (obs !== 22'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", obs); end
        drive(0, 0, 14, 0);
        total++; if (bus.mode !== 1'b0) begin bad++; $display("FAIL key_without_valid mode got=%0d exp=0", bus.mode); end
    endtask

    task automatic test_stopwatch();
        press(11);
        total++; if (bus.sw_cmd !== 2'd1) begin bad++; $display("FAIL sw_start cmd got=%0d exp=1", bus.sw_cmd); end
        total++; if (bus.lap_capture !== 1'b1) begin bad++; $display("FAIL sw_start lap got=%0d exp=1", bus.lap_capture); end
        idle(1);
        total++; if (bus.lap_capture !== 1'b0) begin bad++; $display("FAIL lap_one_cycle got=%0d exp=0", bus.lap_capture); end
        press(13);
        total++; if (bus.sw_cmd !== 2'd0) begin bad++; $display("FAIL sw_stop cmd got=%0d exp=0", bus.sw_cmd); end
        press(10);
        total++; if (bus.sw_cmd !== 2'd2) begin bad++; $display("FAIL sw_clear cmd got=%0d exp=2", bus.sw_cmd); end
        press(12);
        total++; if (bus.sw_cmd !== 2'd1 || bus.lap_capture !== 1'b0) begin
            bad++; $display("FAIL sw_resume cmd/lap got=%0d/%0d exp=1/0", bus.sw_cmd, bus.lap_capture); end
        press(7);
        total++; if (bus.sw_cmd !== 2'd1 || bus.mode !== 1'b0) begin
            bad++; $display("FAIL sw_digit_ignored cmd/mode got=%0d/%0d exp=1/0", bus.sw_cmd, bus.mode); end
    endtask

    task automatic test_entry();
        int keys[7] = '{14, 4, 2, 7, 14, 5, 11};
        int starts = 0;
        for (int i = 0; i < 7; i++) begin
            press(keys[i]);
            starts += int'(bus.calc_start);
            if (i == 0) begin
                total++; if (bus.mode !== 1'b1 || bus.sw_cmd !== 2'd1) begin
                    bad++; $display("FAIL enter_calc mode/sw_cmd got=%0d/%0d exp=1/1", bus.mode, bus.sw_cmd); end
            end
            if (i < 6) begin
                for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                    idle(1);
                    starts += int'(bus.calc_start);
                end
            end
        end
        for (int j = 0; j < 3; j++) begin
            idle(1);
            starts += int'(bus.calc_start);
        end
        total++; if (bus.operand_a !== 7'd42) begin bad++; $display("FAIL entry operand_a got=%0d exp=42", bus.operand_a); end
        total++; if (bus.operand_b !== 7'd5) begin bad++; $display("FAIL entry operand_b got=%0d exp=5", bus.operand_b); end
        total++; if (bus.op !== 1'b0) begin bad++; $display("FAIL entry op got=%0d exp=0", bus.op); end
        total++; if (starts != 1) begin bad++; $display("FAIL entry calc_start pulses got=%0d exp=1", starts); end
    endtask

    task automatic test_exec_ignore();
        press(13);
        total++; if (bus.mode !== 1'b1 || bus.result_valid !== 1'b0) begin
            bad++; $display("FAIL exec_stop_ignored mode/rv got=%0d/%0d exp=1/0", bus.mode, bus.result_valid); end
        press(3);
        total++; if (bus.operand_a !== 7'd42 || bus.operand_b !== 7'd5) begin
            bad++; $display("FAIL exec_operands_stable a/b got=%0d/%0d exp=42/5", bus.operand_a, bus.operand_b); end
        drive(0, 1, 13, 1);
        total++; if (bus.result_valid !== 1'b1 || bus.mode !== 1'b1) begin
            bad++; $display("FAIL done_wins rv/mode got=%0d/%0d exp=1/1", bus.result_valid, bus.mode); end
        total++; if (bus.operand_a !== 7'd42 || bus.operand_b !== 7'd5) begin
            bad++; $display("FAIL done_wins a/b got=%0d/%0d exp=42/5", bus.operand_a, bus.operand_b); end
    endtask

    task automatic test_result_chain();
        press(15);
        total++; if (bus.op !== 1'b1 || bus.operand_b !== 7'd0 || bus.operand_a !== 7'd42) begin
            bad++; $display("FAIL chain op/a/b got=%0d/%0d/%0d exp=1/42/0", bus.op, bus.operand_a, bus.operand_b); end
        press(5);
        press(11);
        total++; if (bus.calc_start !== 1'b1) begin bad++; $display("FAIL chain calc_start got=%0d exp=1", bus.calc_start); end
        drive(0, 0, 0, 1);
        press(3);
        total++; if (bus.operand_a !== 7'd3 || bus.operand_b !== 7'd0 || bus.result_valid !== 1'b0) begin
            bad++; $display("FAIL new_entry a/b/rv got=%0d/%0d/%0d exp=3/0/0", bus.operand_a, bus.operand_b, bus.result_valid); end
        press(7);
        press(9);
        total++; if (bus.operand_a !== 7'd37) begin bad++; $display("FAIL new_entry second digit got=%0d exp=37", bus.operand_a); end
        drive(0, 0, 0, 1);
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL done_outside_exec rv got=%0d exp=0", bus.result_valid); end
    endtask

    task automatic test_clear_exit();
        press(14);
        press(8);
        total++; if (bus.operand_b !== 7'd8) begin bad++; $display("FAIL calc_b digit got=%0d exp=8", bus.operand_b); end
        press(10);
        total++; if (bus.operand_a !== 7'd0 || bus.operand_b !== 7'd0) begin
            bad++; $display("FAIL clear a/b got=%0d/%0d exp=0/0", bus.operand_a, bus.operand_b); end
        press(11);
        total++; if (bus.calc_start !== 1'b0 || bus.mode !== 1'b1) begin
            bad++; $display("FAIL calc_a_equals_ignored start/mode got=%0d/%0d exp=0/1", bus.calc_start, bus.mode); end
        press(13);
        total++; if (bus.mode !== 1'b0 || bus.sw_cmd !== 2'd1 || bus.result_valid !== 1'b0) begin
            bad++; $display("FAIL exit mode/sw_cmd/rv got=%0d/%0d/%0d exp=0/1/0", bus.mode, bus.sw_cmd, bus.result_valid); end
    endtask

    task automatic test_timeout();
        press(14); press(1); press(14); press(2); press(11);
`ifdef MODE_SEQ_TIMEOUT_EN
        idle(int'(TMO) - 1);
        total++; if (bus.calc_error !== 1'b0 || bus.mode !== 1'b1) begin
            bad++; $display("FAIL timeout_early err/mode got=%0d/%0d exp=0/1", bus.calc_error, bus.mode); end
        idle(1);
        total++; if (bus.calc_error !== 1'b1 || bus.result_valid !== 1'b0) begin
            bad++; $display("FAIL timeout err/rv got=%0d/%0d exp=1/0", bus.calc_error, bus.result_valid); end
        press(14);
        total++; if (bus.calc_error !== 1'b1 || bus.operand_b !== 7'd0) begin
            bad++; $display("FAIL timeout_chain err/b got=%0d/%0d exp=1/0", bus.calc_error, bus.operand_b); end
        press(10);
        total++; if (bus.calc_error !== 1'b0) begin bad++; $display("FAIL err_clear_on_calc_a got=%0d exp=0", bus.calc_error); end
`else
        idle(40);
        total++; if (bus.calc_error !== 1'b0 || bus.result_valid !== 1'b0 || bus.mode !== 1'b1) begin
            bad++; $display("FAIL exec_waits err/rv/mode got=%0d/%0d/%0d exp=0/0/1", bus.calc_error, bus.result_valid, bus.mode); end
        drive(0, 0, 0, 1);
        total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL late_done rv got=%0d exp=1", bus.result_valid); end
`endif
        press(13);
        press(14); press(6); press(14); press(6); press(11);
        idle(3);
        drive(1, 1, 13, 1);
        total++; if (obs !== 22'd0) begin bad++; $display("FAIL reset_mid_exec got=%h exp=0", obs); end
        idle(1);
        total++; if (obs !== 22'd0) begin bad++; $display("FAIL after_reset_idle got=%h exp=0", obs); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 255) == 0) ? 1 : 0,
                  ($urandom_range(0, 9) < 7) ? 1 : 0,
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 2) ? 1 : 0);
            total++;
            if (obs !== model_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, obs, model_vec());
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.key       = '0;
        bus.key_valid = 1'b0;
        bus.calc_done = 1'b0;
        test_reset();
        test_stopwatch();
        test_entry();
        test_exec_ignore();
        test_result_chain();
        test_clear_exit();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1023, maximum calc_done wait in clock cycles.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 key  in  4  keypad code: 0-9 digit, 10 clear, 11 start/equals, 12 resume, 13 stop/exit, 14 add, 15 subtract.
REQ-006 key_valid  in  1  one-cycle strobe per key press.
REQ-007 calc_done  in  1  one-cycle strobe from calculator, result ready.
REQ-008 mode  out  1  0 stopwatch, 1 calculator.
REQ-009 sw_cmd  out  2  stopwatch command, level: 0 stop, 1 run, 2 clear.
REQ-010 lap_capture  out  1  one-cycle pulse to latch displayed seconds.
REQ-011 operand_a, operand_b  out  7 each  operands, 0-99.
REQ-012 op  out  1  0 add, 1 subtract.
REQ-013 calc_start  out  1  one-cycle pulse to start calculator.
REQ-014 result_valid  out  1  result display enable; 0 means blank digits.
REQ-015 calc_error  out  1  timeout flag (see Configuration).

Function
REQ-016 States SHALL be SW, CALC_A, CALC_B, EXEC, RESULT.
REQ-017 All outputs SHALL be registered; every response SHALL appear on the cycle after the key_valid or calc_done sample.
REQ-018 Key codes SHALL be acted on only when key_valid=1.
REQ-019 In SW: 11 -> sw_cmd=1 and lap_capture pulse; 12 -> sw_cmd=1; 13 -> sw_cmd=0; 10 -> sw_cmd=2; digits ignored.
REQ-020 In SW, 14/15 SHALL set op (0/1), clear both operands and result_valid, and enter CALC_A with mode=1.
REQ-021 sw_cmd SHALL hold its value while mode=1.
REQ-022 In CALC_A/CALC_B, a digit d SHALL update the active operand to operand*10+d when the operand holds fewer than 2 entered digits; a third digit SHALL be ignored.
REQ-023 A leading 0 SHALL count as an entered digit.
REQ-024 In CALC_A, 14/15 SHALL set op and enter CALC_B; in CALC_B, 14/15 SHALL only update op.
REQ-025 In CALC_B, 11 SHALL pulse calc_start for exactly one cycle and enter EXEC.
REQ-026 In CALC_A, 11 SHALL be ignored.
REQ-027 In CALC_A/CALC_B, 10 SHALL clear both operands and return to CALC_A.
REQ-028 In any calculator state, 13 SHALL return to SW with mode=0 and result_valid=0.
REQ-029 In EXEC, all keys SHALL be ignored, including 13; operands SHALL remain stable.
REQ-030 In EXEC, calc_done SHALL set result_valid=1 and enter RESULT.
REQ-031 If key_valid and calc_done coincide in EXEC, calc_done SHALL win and the key SHALL be dropped.
REQ-032 In RESULT, a digit d SHALL start a new entry: A=d, B=0, result_valid=0, state CALC_A.
REQ-033 In RESULT, 14/15 SHALL chain: A unchanged, B=0, op set, state CALC_B.
REQ-034 calc_done outside EXEC SHALL be ignored.

Reset
REQ-035 On rst the block SHALL enter state SW with mode=0, sw_cmd=0, both operands=0, op=0, result_valid=0, and calc_error=0.
REQ-036 On rst all pulse outputs SHALL be 0 and the digit counters and timeout counter SHALL be 0.
REQ-037 rst SHALL take priority over every key, including during EXEC.

Configuration
REQ-038 With macro MODE_SEQ_TIMEOUT_EN defined, EXEC SHALL count cycles.
REQ-039 With MODE_SEQ_TIMEOUT_EN defined and no calc_done after TIMEOUT_CYCLES cycles, the block SHALL set calc_error=1, result_valid=0, and enter RESULT.
REQ-040 With MODE_SEQ_TIMEOUT_EN defined, calc_error SHALL clear on the next entry into CALC_A.
REQ-041 Without MODE_SEQ_TIMEOUT_EN, EXEC SHALL wait indefinitely, calc_error SHALL be tied 0, and no counter logic SHALL be present.

Structure
REQ-042 Package mode_seq_pkg SHALL hold the key code constants, the sw_cmd encodings, and the state enumeration.
REQ-043 Sub-module operand_entry (operand register plus 2-digit counter, with clear, load-digit and accumulate controls) SHALL be instantiated twice.

Verification
REQ-044 Keys 11, 13, 10, 12 in SW -> sw_cmd 1 (lap_capture pulse on the first key only), then 0, 2, 1.
REQ-045 Keys 14, 4, 2, 7, 14, 5, 11 -> operand_a=42 (the 7 is dropped), operand_b=5, op=0, one calc_start pulse.
REQ-046 In EXEC, key_valid and calc_done in the same cycle -> RESULT, result_valid=1, operands unchanged.
REQ-047 In RESULT, key 15 -> CALC_B, op=1, operand_b=0; key 3 -> operand_a=3, result_valid=0.
REQ-048 With MODE_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, no calc_done -> calc_error=1 after 8 EXEC cycles; rst asserted mid-EXEC -> all REQ-035/REQ-036 values on the next cycle.
